// File: rtl/instruction_sequencer_if.sv
// Issue channel between the instruction sequencer and the execution datapath.
//   oValid   : issued instruction fields are valid (sequencer -> datapath)
//   iReady   : datapath accepts the issued instruction (datapath -> sequencer)
//   oOpcode  : issued opcode [27:24]
//   oDest    : issued dest field [23:16]
//   oSrc1    : issued src1 field [15:8]
//   oSrc0    : issued src0 field [7:0]
//   oImm     : issued imm16 field [15:0]
// The master modport is the sequencer side and the slave modport is the datapath side.
interface instruction_sequencer_if;
  logic        oValid;
  logic        iReady;
  logic [3:0]  oOpcode;
  logic [7:0]  oDest;
  logic [7:0]  oSrc1;
  logic [7:0]  oSrc0;
  logic [15:0] oImm;

  modport master (
    output oValid, oOpcode, oDest, oSrc1, oSrc0, oImm,
    input  iReady
  );

  modport slave (
    input  oValid, oOpcode, oDest, oSrc1, oSrc0, oImm,
    output iReady
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Program sequencer. It holds the PC that addresses the instruction ROM and
// executes NOP (a programmable delay) and JMP (an absolute jump) locally. All
// other opcodes go to the datapath through the issue interface.
// Ports:
//   Clock        : system clock; all state changes on the rising edge
//   Reset        : asynchronous, active-low reset
//   oAddress     : ROM address; this is the PC register itself
//   iInstruction : ROM data, combinational from oAddress
//   issue        : valid/ready issue channel (master side)
//   oDelayActive : high while a NOP delay is counting
module instruction_sequencer #(
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned INSN_WIDTH = 28,
  parameter logic [3:0]  OP_NOP     = 4'h0,
  parameter logic [3:0]  OP_JMP     = 4'h1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [PC_WIDTH-1:0]   oAddress,
  input  logic [INSN_WIDTH-1:0] iInstruction,
  instruction_sequencer_if.master issue,
  output logic                  oDelayActive
);

  typedef enum logic [1:0] {
    FETCH,
    DELAY,
    ISSUE
  } state_t;

  state_t        state;
  logic [23:0]   counter;

  // Instruction field decode of the word currently being fetched.
  logic [3:0]    f_opcode;
  logic [7:0]    f_dest;
  logic [7:0]    f_src1;
  logic [7:0]    f_src0;
  logic [15:0]   f_imm16;
  logic [23:0]   f_imm24;

  always_comb begin
    f_opcode = iInstruction[27:24];
    f_dest   = iInstruction[23:16];
    f_src1   = iInstruction[15:8];
    f_src0   = iInstruction[7:0];
    f_imm16  = iInstruction[15:0];
    f_imm24  = iInstruction[23:0];
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= FETCH;
      oAddress      <= '0;
      counter       <= '0;
      oDelayActive  <= 1'b0;
      issue.oValid  <= 1'b0;
      issue.oOpcode <= '0;
      issue.oDest   <= '0;
      issue.oSrc1   <= '0;
      issue.oSrc0   <= '0;
      issue.oImm    <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (f_opcode == OP_NOP) begin
            if (f_imm24 == 24'd0) begin
              oAddress <= oAddress + 1'b1;
            end else begin
              counter      <= f_imm24;
              oDelayActive <= 1'b1;
              state        <= DELAY;
            end
          end else if (f_opcode == OP_JMP) begin
            oAddress <= PC_WIDTH'(f_imm16);
          end else begin
            issue.oOpcode <= f_opcode;
            issue.oDest   <= f_dest;
            issue.oSrc1   <= f_src1;
            issue.oSrc0   <= f_src0;
            issue.oImm    <= f_imm16;
            issue.oValid  <= 1'b1;
            state         <= ISSUE;
          end
        end

        DELAY: begin
          // Loaded with N on the fetch edge, so N DELAY edges follow before
          // the PC advances: N+1 cycles from fetch to the next fetch.
          counter <= counter - 1'b1;
          if (counter == 24'd1) begin
            oAddress     <= oAddress + 1'b1;
            oDelayActive <= 1'b0;
            state        <= FETCH;
          end
        end

        ISSUE: begin
          if (issue.iReady) begin
            issue.oValid <= 1'b0;
            oAddress     <= oAddress + 1'b1;
            state        <= FETCH;
          end
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Program sequencer that drives the address input of the 28-bit instruction ROM and consumes the instruction word it returns. It holds the program counter and executes control-flow opcodes locally: `NOP` as a programmable delay and `JMP` as an absolute jump. All other opcodes are handed to the datapath over a valid/ready handshake. It sits between the ROM and the execution datapath (register file, `MUL`, `LED` output) on the single system clock.

## Interface
- PC_WIDTH, 16, program counter / ROM address width
- INSN_WIDTH, 28, instruction width: opcode [27:24], dest [23:16], src1 [15:8], src0 [7:0]; imm16 = [15:0], imm24 = [23:0]
- Clock  input  1  system clock, all state on rising edge
- Reset  input  1  asynchronous, active-low reset
- oAddress  output  PC_WIDTH  ROM address; equals the PC register
- iInstruction  input  INSN_WIDTH  ROM data, combinational from oAddress
- oValid  output  1  issued instruction fields are valid
- iReady  input  1  datapath accepts the issued instruction
- oOpcode  output  4  issued opcode
- oDest  output  8  issued dest field
- oSrc1  output  8  issued src1 field
- oSrc0  output  8  issued src0 field
- oImm  output  16  issued imm16 field
- oDelayActive  output  1  high while a `NOP` delay is counting

## Operation
- Opcode values come from the shared definitions header (`NOP`, `JMP`, `STO`, `MUL`, `LED`, ...). Any opcode other than `NOP`/`JMP` is issued unmodified.
- State machine with three states: FETCH, DELAY, ISSUE. Reset state is FETCH.
- FETCH samples iInstruction at the current PC, then acts on the opcode:
  - `NOP`, imm24 = 0: PC <= PC+1; stay in FETCH.
  - `NOP`, imm24 = N > 0: counter <= N; oDelayActive <= 1; go to DELAY.
  - `JMP`: PC <= imm16; stay in FETCH. Fields [23:16] are ignored.
  - Other opcodes: register opcode/dest/src1/src0/imm16 onto the outputs; oValid <= 1; go to ISSUE.
- DELAY decrements the 24-bit counter each cycle. On the cycle where counter = 1: PC <= PC+1, oDelayActive <= 0, go to FETCH.
- ISSUE holds oValid and all field outputs stable until iReady = 1 at a rising edge. On that edge: oValid <= 0, PC <= PC+1, go to FETCH. While in ISSUE, iReady = 0 stalls indefinitely.
- PC arithmetic is modulo 2^PC_WIDTH: 16'hFFFF + 1 = 16'h0000. `JMP` to any address is legal, including self (`JMP` to own address is an infinite loop of 1 cycle per iteration).
- Field outputs keep their last issued value after oValid falls. They change only on entry to ISSUE.

## Timing
- Reset (asynchronous assert): PC = 0, state = FETCH, oValid = 0, oDelayActive = 0, counter = 0, oOpcode/oDest/oSrc1/oSrc0/oImm = 0. Reset deassertion takes effect at the next rising edge; the first fetch is address 0.
- Reset asserted in any state aborts that state immediately. A pending issue or delay is discarded.
- Cycle cost, fetch edge to next fetch edge:
  - `NOP` N: N+1 cycles.
  - `JMP`: 1 cycle.
  - Issued instruction: 1 + (number of ISSUE cycles). Minimum is 2 with iReady held high.
- oAddress is a register output. ROM lookup plus the FETCH decision must fit in one cycle.
- iReady is ignored outside ISSUE. Asserting iReady without oValid has no effect.
- `NOP` with imm24 = 24'hFFFFFF: DELAY lasts 16777215 cycles with no overflow.

## Test plan
- Reset: hold Reset = 0 for 3 cycles, then release -> during reset all outputs are 0; the first post-reset edge fetches address 0.
- ROM {`NOP`,24'd4} at addr 0, {`JMP`,8'd0,16'd0} at addr 1 -> oAddress sequence 0,0,0,0,0,1,0,... (5 cycles at 0); oDelayActive high for exactly 4 cycles per loop.
- ROM {`STO`,R0,16'd3} at addr 0 with iReady held 1 -> oValid high for 1 cycle with oOpcode = `STO`, oDest = R0, oImm = 16'd3; oAddress = 1 two cycles after the fetch.
- Same program with iReady = 0 for 5 cycles, then 1 -> oValid high for 6 cycles, fields stable throughout, PC advances only after acceptance.
- `JMP` to 16'hFFFF, where addr 16'hFFFF holds {`NOP`,24'd0} -> oAddress goes FFFF then wraps to 0000.
- Assert Reset mid-DELAY (`NOP` 24'd4000, after 100 cycles) and mid-ISSUE -> oDelayActive and oValid drop asynchronously; the next fetch is address 0.
